// File: rtl/l2_burst_adaptor.sv
// Converts single-cycle 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Optional per-beat watchdog enabled by defining L2_BURST_TIMEOUT_EN.
module l2_burst_adaptor #(
    parameter  int BEAT_W  = 64,
    parameter  int BEATS   = 4,
    parameter  int TIMEOUT = 255,
    localparam int LINE_W  = BEAT_W * BEATS,
    localparam int CNT_W   = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_addr_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i,
    output logic              mem_err_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: the cache holds line_read_i/line_write_i until the one-cycle
    // line_resp_o pulse; on the memory side each cycle with mem_resp_i=1 while
    // mem_read_o/mem_write_o is high transfers exactly one beat.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               resp_q, resp_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [BEAT_W-1:0]  wdata_q, wdata_d;
    logic               last_beat;
    logic [CNT_W-1:0]   cnt_nxt;
    int                 beat_lo;
    int                 nxt_lo;
    logic               unused_ok;

`ifdef L2_BURST_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
`endif

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign cnt_nxt   = cnt_q + 1'b1;
    assign beat_lo   = int'(cnt_q) * BEAT_W;
    assign nxt_lo    = int'(cnt_nxt) * BEAT_W;
    assign unused_ok = ^{line_addr_i[4:0], 8'(TIMEOUT)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
`ifdef L2_BURST_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (line_read_i) begin
                    addr_d  = {line_addr_i[31:5], 5'b0};
                    rd_d    = 1'b1;
                    state_d = RD_BURST;
`ifdef L2_BURST_TIMEOUT_EN
                    err_d   = 1'b0;
                    wdog_d  = '0;
`endif
                end else if (line_write_i) begin
                    addr_d  = {line_addr_i[31:5], 5'b0};
                    wline_d = line_wdata_i;
                    wdata_d = line_wdata_i[BEAT_W-1:0];
                    wr_d    = 1'b1;
                    state_d = WR_BURST;
`ifdef L2_BURST_TIMEOUT_EN
                    err_d   = 1'b0;
                    wdog_d  = '0;
`endif
                end
            end
            RD_BURST: begin
                if (mem_resp_i) begin
                    rdata_d[beat_lo +: BEAT_W] = mem_rdata_i;
                    if (last_beat) begin
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            WR_BURST: begin
                if (mem_resp_i) begin
                    if (last_beat) begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_nxt;
                        wdata_d = wline_q[nxt_lo +: BEAT_W];
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef L2_BURST_TIMEOUT_EN
        // A silent memory must not hang the cache: give up and still pulse resp.
        if (state_q == RD_BURST || state_q == WR_BURST) begin
            if (mem_resp_i) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_LAST) begin
                wdog_d  = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                wdata_d = '0;
                resp_d  = 1'b1;
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                wdog_d = wdog_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
`ifdef L2_BURST_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
`ifdef L2_BURST_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign line_rdata_o = rdata_q;
    assign line_resp_o  = resp_q;
    assign mem_addr_o   = addr_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign mem_wdata_o  = wdata_q;
    assign dbg_state_o  = state_q;
`ifdef L2_BURST_TIMEOUT_EN
    assign mem_err_o    = err_q;
`else
    assign mem_err_o    = 1'b0;
`endif

endmodule
